// File: rtl/c8051_pkg.sv
// Shared definitions for the 8051 serial port blocks: receive FSM states,
// oversampling constants and the 2-of-3 majority helper.
package c8051_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned SAMPLE_LO     = 7;
  localparam int unsigned SAMPLE_DECIDE = 9;
  localparam int unsigned DATA_BITS     = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Oversample tick generator: counts 0..CLK_DIV-1 and pulses o_tick for one
// cycle on the terminal count. i_clr restarts the count synchronously.
module serial_baud_tick #(
  parameter int unsigned CLK_DIV = 54
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] r_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (i_clr || (r_div == LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  assign o_tick = !i_clr && (r_div == LAST);

endmodule

// File: rtl/serial_rx.sv
// 8051 serial port mode 1 receiver (start, 8 data LSB first, stop) with 16x
// oversampling and 2-of-3 majority voting. Define SERIAL_RX_SM2_EN for sm2.
module serial_rx
  import c8051_pkg::*;
#(
  parameter int unsigned CLK_DIV = 54
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ren,
`ifdef SERIAL_RX_SM2_EN
  input  logic       sm2,
`endif
  input  logic       ri_clr,
  output logic [7:0] sbuf,
  output logic       rb8,
  output logic       ri,
  output logic       busy
);

  localparam logic [3:0] SUB_LO     = 4'(SAMPLE_LO);
  localparam logic [3:0] SUB_MID    = 4'(SAMPLE_LO + 1);
  localparam logic [3:0] SUB_DECIDE = 4'(SAMPLE_DECIDE);
  localparam logic [3:0] SUB_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS);

  rx_state_t   r_state;
  logic        r_sync1;
  logic        r_rs;
  logic        r_rs_d;
  logic [3:0]  r_sub;
  logic [3:0]  r_bit;
  logic        r_s_lo;
  logic        r_s_mid;
  logic [7:0]  r_shift;
  logic [7:0]  r_sbuf;
  logic        r_rb8;
  logic        r_ri;
  logic        r_busy;

  logic        w_tick;
  logic        w_clr;
  logic        w_sm2;
  logic        w_maj;
  logic        w_decide;
  logic        w_wrap;
  logic        w_load;

`ifdef SERIAL_RX_SM2_EN
  assign w_sm2 = sm2;
`else
  assign w_sm2 = 1'b0;
`endif

  // Divider is held in clear while idle so tick 1 lands CLK_DIV cycles after detection.
  assign w_clr = (r_state == IDLE);

  serial_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  assign w_maj    = maj3(r_s_lo, r_s_mid, r_rs);
  assign w_decide = (r_sub == SUB_DECIDE);
  assign w_wrap   = (r_sub == SUB_LAST);
  assign w_load   = !r_ri && (!w_sm2 || w_maj);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rs    <= 1'b1;
      r_rs_d  <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rs    <= r_sync1;
      r_rs_d  <= r_rs;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sub   <= '0;
      r_bit   <= '0;
      r_s_lo  <= 1'b0;
      r_s_mid <= 1'b0;
      r_shift <= '0;
      r_sbuf  <= '0;
      r_rb8   <= 1'b0;
      r_ri    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // A load later in this block overrides the clear in the same cycle.
      if (ri_clr) begin
        r_ri <= 1'b0;
      end

      if (r_state == IDLE) begin
        r_sub <= '0;
        r_bit <= '0;
        if (ren && !r_rs && r_rs_d) begin
          r_state <= START;
          r_busy  <= 1'b1;
        end
      end else if (!ren) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_sub   <= '0;
      end else if (w_tick) begin
        r_sub <= r_sub + 4'd1;
        if (r_sub == SUB_LO) begin
          r_s_lo <= r_rs;
        end
        if (r_sub == SUB_MID) begin
          r_s_mid <= r_rs;
        end

        unique case (r_state)
          START: begin
            if (w_decide && w_maj) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_sub   <= '0;
            end else if (w_wrap) begin
              r_state <= DATA;
              r_bit   <= 4'd1;
            end
          end
          DATA: begin
            if (w_decide) begin
              r_shift <= {w_maj, r_shift[7:1]};
            end
            if (w_wrap) begin
              if (r_bit == LAST_DATA) begin
                r_state <= STOP;
              end
              r_bit <= r_bit + 4'd1;
            end
          end
          STOP: begin
            // Leave at the decision tick so the next start edge is caught early.
            if (w_decide) begin
              if (w_load) begin
                r_sbuf <= r_shift;
                r_rb8  <= w_maj;
                r_ri   <= 1'b1;
              end
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_sub   <= '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sbuf = r_sbuf;
  assign rb8  = r_rb8;
  assign ri   = r_ri;
  assign busy = r_busy;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: frames are driven at 64 clocks per bit with
// CLK_DIV=4, expected loads are queued and checked when ri rises.
module tb_serial_rx;

  localparam int unsigned CLK_DIV  = 4;
  localparam int          BIT_CLKS = 64;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       rxd    = 1'b1;
  logic       ren    = 1'b0;
  logic       ri_clr = 1'b0;
`ifdef SERIAL_RX_SM2_EN
  logic       sm2    = 1'b0;
`endif
  logic [7:0] sbuf;
  logic       rb8;
  logic       ri;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
  } exp_t;

  exp_t q[$];

  // Reference model state: what the SFR view should hold after each frame.
  logic       m_ri   = 1'b0;
  logic       m_sm2  = 1'b0;
  logic       m_rb8  = 1'b0;
  logic [7:0] m_sbuf = 8'h00;

  always #5 clock = ~clock;

  serial_rx #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rxd   (rxd),
    .ren   (ren),
`ifdef SERIAL_RX_SM2_EN
    .sm2   (sm2),
`endif
    .ri_clr(ri_clr),
    .sbuf  (sbuf),
    .rb8   (rb8),
    .ri    (ri),
    .busy  (busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A completed frame loads only if RI is free and (SM2 off or stop bit set).
  task automatic expect_frame(input logic [7:0] d, input logic s);
    if (!m_ri && (!m_sm2 || s)) begin
      q.push_back(exp_t'{d, s});
      m_ri   = 1'b1;
      m_sbuf = d;
      m_rb8  = s;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s, input int idle);
    logic [9:0] bits;
    bits = {s, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (BIT_CLKS) @(negedge clock);
    end
    rxd = 1'b1;
    repeat (idle) @(negedge clock);
  endtask

  task automatic post_check(input string tag);
    chk1({tag, "_ri"}, ri, m_ri);
    chk8({tag, "_sbuf"}, sbuf, m_sbuf);
    chk1({tag, "_rb8"}, rb8, m_rb8);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic frame(input logic [7:0] d, input logic s, input int idle, input string tag);
    expect_frame(d, s);
    send_frame(d, s, idle);
    post_check(tag);
  endtask

  task automatic clear_ri();
    ri_clr = 1'b1;
    @(negedge clock);
    ri_clr = 1'b0;
    m_ri   = 1'b0;
    @(negedge clock);
  endtask

  // Monitor: every rising edge of ri is a load and must match the queue head.
  initial begin
    logic prev_ri;
    exp_t e;
    prev_ri = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && ri && !prev_ri) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_load: sbuf=%h rb8=%b with no frame expected at %0t",
                   sbuf, rb8, $time);
        end else begin
          e = q.pop_front();
          chk8("mon_sbuf", sbuf, e.data);
          chk1("mon_rb8", rb8, e.stop);
        end
      end
      prev_ri = ri;
    end
  end

  initial begin
    logic [7:0] d;
    logic       s;
    int         idle;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk8("rst_sbuf", sbuf, 8'h00);
    chk1("rst_rb8", rb8, 1'b0);
    chk1("rst_ri", ri, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    ren   = 1'b1;
    repeat (5) @(negedge clock);

    // Basic frame with exact load timing: D is 3 edges after the pin falls.
    expect_frame(8'hA5, 1'b1);
    fork
      send_frame(8'hA5, 1'b1, 5);
      begin
        repeat (618) @(posedge clock);
        @(negedge clock);
        chk1("pre_load_ri", ri, 1'b0);
        chk1("pre_load_busy", busy, 1'b1);
        @(negedge clock);
        chk1("load_ri", ri, 1'b1);
        chk1("load_busy", busy, 1'b0);
        chk8("load_sbuf", sbuf, 8'hA5);
      end
    join
    post_check("basic");
    clear_ri();

    // False start: low for 20 clocks only.
    rxd = 1'b0;
    repeat (20) @(negedge clock);
    rxd = 1'b1;
    repeat (10) @(negedge clock);
    chk1("false_start_busy_mid", busy, 1'b1);
    repeat (40) @(negedge clock);
    post_check("false_start");

    // Overrun: second frame is dropped while ri is still set.
    frame(8'h3C, 1'b1, 0, "ovr1");
    frame(8'hC3, 1'b1, 5, "ovr2");
    clear_ri();
    chk1("ovr_clr_ri", ri, 1'b0);
    frame(8'h5A, 1'b1, 5, "ovr3");
    clear_ri();

`ifdef SERIAL_RX_SM2_EN
    sm2   = 1'b1;
    m_sm2 = 1'b1;
    frame(8'h11, 1'b0, 8, "sm2_stop0");
    frame(8'h11, 1'b1, 8, "sm2_stop1");
    sm2   = 1'b0;
    m_sm2 = 1'b0;
`else
    frame(8'h11, 1'b0, 8, "nosm2_stop0");
`endif
    clear_ri();

    // ri_clr coinciding with the load edge: load wins.
    expect_frame(8'h66, 1'b1);
    fork
      send_frame(8'h66, 1'b1, 5);
      begin
        repeat (618) @(posedge clock);
        @(negedge clock);
        ri_clr = 1'b1;
        @(negedge clock);
        ri_clr = 1'b0;
        chk1("collide_ri", ri, 1'b1);
      end
    join
    post_check("collide");
    clear_ri();

    // REN dropped in the middle of data bit 4.
    fork
      send_frame(8'h99, 1'b1, 5);
      begin
        repeat (287) @(negedge clock);
        chk1("ren_busy_before", busy, 1'b1);
        ren = 1'b0;
        @(negedge clock);
        chk1("ren_busy_after", busy, 1'b0);
      end
    join
    post_check("ren_abort");
    ren = 1'b1;
    @(negedge clock);
    frame(8'h0F, 1'b1, 5, "after_ren");

    // Randomized frames against the model.
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
`ifdef SERIAL_RX_SM2_EN
      sm2   = 1'($urandom_range(0, 1));
      m_sm2 = sm2;
`endif
      if ($urandom_range(0, 1) == 1) begin
        clear_ri();
      end
      idle = s ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      frame(d, s, idle, "rand");
    end
`ifdef SERIAL_RX_SM2_EN
    sm2   = 1'b0;
    m_sm2 = 1'b0;
`endif

    // Asynchronous reset during data bit 5.
    clear_ri();
    frame(8'hC9, 1'b1, 5, "pre_reset");
    fork
      send_frame(8'h77, 1'b1, 5);
      begin
        repeat (350) @(negedge clock);
        reset = 1'b0;
        #1;
        chk8("arst_sbuf", sbuf, 8'h00);
        chk1("arst_rb8", rb8, 1'b0);
        chk1("arst_ri", ri, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        m_ri   = 1'b0;
        m_sbuf = 8'h00;
        m_rb8  = 1'b0;
      end
    join
    reset = 1'b1;
    repeat (3) @(negedge clock);
    frame(8'hFF, 1'b1, 5, "post_reset");

    chk8("queue_empty", 8'(q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
